xbar_router: RTL and testbench

Parametrised PE-to-accumulator crossbar: up to `NUM_SRC` PE output packets per cycle are routed by coordinate to one of `NUM_DST` accumulate-buffer banks. Each bank has a multi-write, single-read FIFO.
- Per-destination round-robin arbitration limits writes to `WR_PORTS` per bank per cycle.
- Per-source `in_ready` provides lossless backpressure; no FIFO overflows.
- Per-bank `out_ready` accepts backpressure from the accumulate buffers.
- Sits between the PE multiplier array and the accumulate buffers.

---
 rtl/xbar_router_pkg.sv | 24 ++
 rtl/xbar_bank_fifo.sv | 65 ++++++
 rtl/xbar_router.sv | 135 +++++++++++++
 tb/tb_xbar_router.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/xbar_router_pkg.sv
// Shared types for the PE-to-accumulator crossbar: the packet format
// and the route_mode encoding.
package xbar_router_pkg;

  localparam int COORD_W   = 8;
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [PAYLOAD_W-1:0] payload;
  } data_packet_t;

  typedef enum logic {
    ROUTE_Y = 1'b0,
    ROUTE_X = 1'b1
  } route_mode_e;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/xbar_bank_fifo.sv
// One accumulate-bank FIFO: up to WR_PORTS pushes and one pop per cycle.
// The count register (not pointer equality) separates full from empty.
module xbar_bank_fifo
  import xbar_router_pkg::*;
#(
  parameter int  DEPTH    = 16,
  parameter int  WR_PORTS = 2,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int PW       = $clog2(DEPTH),
  localparam int WCW      = $clog2(WR_PORTS + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  input  logic [WCW-1:0] wr_count,
  input  data_packet_t   wr_data [WR_PORTS],
  input  logic           rd_ready,
  output data_packet_t   rd_data,
  output logic           rd_valid,
  output logic [CW-1:0]  occupancy
);

  data_packet_t  mem_q [DEPTH];
  data_packet_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;

  assign rd_valid  = (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = count_q;
  // A pop on an empty bank is ignored even if a push lands in the same cycle.
  assign pop       = rd_valid && rd_ready;

  always_comb begin
    mem_d = mem_q;
    for (int l = 0; l < WR_PORTS; l++) begin
      if (l < int'(wr_count)) begin
        mem_d[wr_ptr_q + PW'(l)] = wr_data[l];
      end
    end
    wr_ptr_d = wr_ptr_q + PW'(wr_count);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(wr_count) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no clear: stale entries are never visible once the pointers reset.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/xbar_router.sv
// Crossbar from NUM_SRC PE outputs to NUM_DST accumulate banks with
// per-bank round-robin arbitration limited by WR_PORTS and free space.
module xbar_router
  import xbar_router_pkg::*;
#(
  parameter int  NUM_SRC     = 8,
  parameter int  NUM_DST     = 8,
  parameter int  FIFO_DEPTH  = 16,
  parameter int  WR_PORTS    = 2,
  parameter int  ALMOST_FULL = FIFO_DEPTH / 2,
  localparam int CW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 route_mode,
  input  data_packet_t         in_packet [NUM_SRC],
  output logic [NUM_SRC-1:0]   in_ready,
  output data_packet_t         out_packet [NUM_DST],
  output logic [NUM_DST-1:0]   out_valid,
  input  logic [NUM_DST-1:0]   out_ready,
  output logic [CW-1:0]        occupancy [NUM_DST],
  output logic                 busy
);

  localparam int DSW = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam int SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WCW = $clog2(WR_PORTS + 1);

  logic [DSW-1:0]     dst [NUM_SRC];
  logic [NUM_SRC-1:0] grant_mat [NUM_DST];
  logic               busy_q, busy_d;

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (NUM_DST == 1) begin
        dst[s] = '0;
      end else if (route_mode == ROUTE_X) begin
        dst[s] = in_packet[s].x[DSW-1:0];
      end else begin
        dst[s] = in_packet[s].y[DSW-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_bank
    logic [NUM_SRC-1:0] grant;
    data_packet_t       lane_data [WR_PORTS];
    logic [WCW-1:0]     lane_count;
    logic [SW-1:0]      rr_ptr_q, rr_ptr_d;

    // Free space comes from registered occupancy only, so out_ready never reaches in_ready.
    always_comb begin
      int idx;
      int cnt;
      int limit;
      int last;
      grant    = '0;
      rr_ptr_d = rr_ptr_q;
      for (int l = 0; l < WR_PORTS; l++) begin
        lane_data[l] = '0;
      end
      limit = min_int(WR_PORTS, FIFO_DEPTH - int'(occupancy[gi]));
      cnt   = 0;
      last  = -1;
      idx   = int'(rr_ptr_q);
      for (int k = 0; k < NUM_SRC; k++) begin
        if (cnt < limit && in_packet[idx].valid && dst[idx] == DSW'(gi)) begin
          grant[idx]     = 1'b1;
          lane_data[cnt] = in_packet[idx];
          cnt            = cnt + 1;
          last           = idx;
        end
        idx = (idx == NUM_SRC - 1) ? 0 : idx + 1;
      end
      lane_count = WCW'(cnt);
      if (last >= 0) begin
        rr_ptr_d = (last == NUM_SRC - 1) ? '0 : SW'(last + 1);
      end
    end

    always_ff @(posedge clock) begin
      if (reset || flush) begin
        rr_ptr_q <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
      end
    end

    assign grant_mat[gi] = grant;

    xbar_bank_fifo #(
      .DEPTH    (FIFO_DEPTH),
      .WR_PORTS (WR_PORTS)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .wr_count  (lane_count),
      .wr_data   (lane_data),
      .rd_ready  (out_ready[gi]),
      .rd_data   (out_packet[gi]),
      .rd_valid  (out_valid[gi]),
      .occupancy (occupancy[gi])
    );
  end

  always_comb begin
    in_ready = '0;
    for (int d = 0; d < NUM_DST; d++) begin
      in_ready = in_ready | grant_mat[d];
    end
    in_ready = in_ready & {NUM_SRC{~(reset | flush)}};
  end

  always_comb begin
    busy_d = 1'b0;
    for (int d = 0; d < NUM_DST; d++) begin
      if (int'(occupancy[d]) >= ALMOST_FULL) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_xbar_router.sv
// Directed bench for xbar_router with default parameters (8 src, 8 banks,
// depth 16, 2 write ports); one report line per failed check.
module tb_xbar_router;
  import xbar_router_pkg::*;

  logic         clock;
  logic         reset;
  logic         flush;
  logic         route_mode;
  data_packet_t in_packet [8];
  logic [7:0]   in_ready;
  data_packet_t out_packet [8];
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [4:0]   occupancy [8];
  logic         busy;

  int checks = 0;
  int errors = 0;

  xbar_router dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .route_mode (route_mode),
    .in_packet  (in_packet),
    .in_ready   (in_ready),
    .out_packet (out_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_all();
    for (int s = 0; s < 8; s++) in_packet[s] = '0;
  endtask

  task automatic set_pkt(input int s, input int x, input int y, input int p);
    in_packet[s] = '{valid: 1'b1, x: 8'(x), y: 8'(y), payload: 16'(p)};
  endtask

  initial begin
    data_packet_t ep;
    reset = 1'b1; flush = 1'b0; route_mode = 1'b0; out_ready = '0;
    clear_all();
    set_pkt(0, 0, 3, 16'h00A1);
    tick(); tick();

    // Reset state
    check("in_ready_during_reset", in_ready, 8'h00);
    check("out_valid_reset", out_valid, 8'h00);
    check("busy_reset", busy, 1'b0);
    check("out_packet3_reset", out_packet[3], '0);
    for (int d = 0; d < 8; d++) check($sformatf("occ%0d_reset", d), occupancy[d], 5'd0);

    // Latency after reset
    reset = 1'b0; #1;
    check("in_ready_first", in_ready, 8'h01);
    ep = '{valid: 1'b1, x: 8'd0, y: 8'd3, payload: 16'h00A1};
    tick(); clear_all();
    check("lat_out_valid", out_valid, 8'h08);
    check("lat_packet", out_packet[3], ep);
    check("lat_occ3", occupancy[3], 5'd1);
    out_ready[3] = 1'b1;
    tick(); out_ready = '0;
    check("lat_pop_valid", out_valid, 8'h00);
    check("lat_pop_occ3", occupancy[3], 5'd0);

    // Round-robin: all eight sources into bank 2
    for (int s = 0; s < 8; s++) set_pkt(s, 0, 2, 16'h20 + s);
    #1 check("rr_grant_01", in_ready, 8'h03);
    tick(); in_packet[0] = '0; in_packet[1] = '0; #1;
    check("rr_grant_23", in_ready, 8'h0C);
    tick(); in_packet[2] = '0; in_packet[3] = '0; #1;
    check("rr_grant_45", in_ready, 8'h30);
    tick(); in_packet[4] = '0; in_packet[5] = '0; #1;
    check("rr_grant_67", in_ready, 8'hC0);
    tick(); clear_all();
    check("rr_occ2", occupancy[2], 5'd8);
    tick();
    check("rr_busy", busy, 1'b1);
    out_ready[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr_drain%0d", k), out_packet[2].payload, 16'(16'h20 + k));
      tick();
    end
    out_ready = '0;
    check("rr_drained", out_valid[2], 1'b0);
    // Pointer wrapped to 0: sources 0,1 beat source 7
    set_pkt(7, 0, 2, 16'h37); set_pkt(0, 0, 2, 16'h30); set_pkt(1, 0, 2, 16'h31);
    #1 check("rr_wrap_grant", in_ready, 8'h03);
    tick(); in_packet[0] = '0; in_packet[1] = '0; #1;
    check("rr_wrap_grant7", in_ready, 8'h80);
    tick(); clear_all();
    check("rr_wrap_occ2", occupancy[2], 5'd3);
    out_ready[2] = 1'b1;
    check("rr_wrap_head0", out_packet[2].payload, 16'h30); tick();
    check("rr_wrap_head1", out_packet[2].payload, 16'h31); tick();
    check("rr_wrap_head2", out_packet[2].payload, 16'h37); tick();
    out_ready = '0;
    check("rr_wrap_empty", occupancy[2], 5'd0);

    // Full bank 5 with consumer stalled
    for (int s = 0; s < 8; s++) set_pkt(s, 0, 5, 16'h50 + s);
    for (int k = 0; k < 8; k++) tick();
    check("full_occ5", occupancy[5], 5'd16);
    check("full_in_ready", in_ready, 8'h00);
    check("full_busy", busy, 1'b1);
    out_ready[5] = 1'b1; #1;
    check("full_same_cycle_pop", in_ready, 8'h00);
    tick();
    check("full_after_pop_occ5", occupancy[5], 5'd15);
    check("full_resume", in_ready, 8'h01);
    clear_all(); out_ready = '0;
    tick();
    check("full_hold_occ5", occupancy[5], 5'd15);

    // Wrap-around: 40 packets through bank 0
    out_ready[0] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_pkt(0, 0, 0, 16'h100 + k);
      tick();
      check($sformatf("wrap_head%0d", k), out_packet[0].payload, 16'(16'h100 + k));
      check($sformatf("wrap_occ%0d", k), occupancy[0], 5'd1);
    end
    clear_all();
    tick();
    out_ready = '0;
    check("wrap_empty", out_valid[0], 1'b0);

    // Routing modes
    route_mode = 1'b1;
    set_pkt(3, 9, 0, 16'hBEEF);
    tick(); clear_all();
    check("route_x_bank1", out_valid[1], 1'b1);
    check("route_x_not_bank0", out_valid[0], 1'b0);
    check("route_x_payload", out_packet[1].payload, 16'hBEEF);
    route_mode = 1'b0;
    set_pkt(3, 9, 0, 16'hCAFE);
    tick(); clear_all();
    check("route_y_bank0", out_valid[0], 1'b1);
    check("route_y_payload", out_packet[0].payload, 16'hCAFE);

    // Flush with banks 0, 1 and 5 non-empty; source 2 holds a packet
    check("pre_flush_valid", out_valid, 8'h23);
    check("pre_flush_busy", busy, 1'b1);
    set_pkt(2, 0, 4, 16'h0444);
    flush = 1'b1; #1;
    check("flush_in_ready", in_ready, 8'h00);
    tick(); flush = 1'b0; #1;
    check("flush_out_valid", out_valid, 8'h00);
    check("flush_busy", busy, 1'b0);
    for (int d = 0; d < 8; d++) check($sformatf("flush_occ%0d", d), occupancy[d], 5'd0);
    check("flush_held_ready", in_ready, 8'h04);
    tick(); clear_all();
    check("flush_held_valid", out_valid, 8'h10);
    check("flush_held_payload", out_packet[4].payload, 16'h0444);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
